// File: rtl/fft_stage_sequencer.sv
// Address sequencer for an in-place radix-2 DIT FFT: issues butterfly read and twiddle
// addresses stage by stage, then replays them delayed by BF_LAT as write-back addresses.
module fft_stage_sequencer #(
  parameter int N      = 16,
  parameter int SIZE   = 4,
  parameter int BF_LAT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  output logic            rd_en_o,
  output logic [SIZE-1:0] rd_addr_a_o,
  output logic [SIZE-1:0] rd_addr_b_o,
  output logic [SIZE-2:0] tw_addr_o,
  output logic            wr_en_o,
  output logic [SIZE-1:0] wr_addr_a_o,
  output logic [SIZE-1:0] wr_addr_b_o,
  output logic [SIZE-1:0] stage_o,
  output logic            busy_o,
  output logic            done_o
);

  localparam int CW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam logic [SIZE-2:0] K_LAST     = (SIZE-1)'(N/2 - 1);
  localparam logic [SIZE-1:0] STAGE_LAST = SIZE'(SIZE - 1);
  localparam logic [CW-1:0]   CNT_LAST   = CW'(BF_LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  typedef struct packed {
    logic            v;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
  } wb_t;

  state_e          state_q, state_d;
  logic [SIZE-2:0] k_q, k_d;
  logic [SIZE-1:0] stage_q, stage_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            rd_en_q, rd_en_d;
  logic [SIZE-1:0] rd_a_q, rd_a_d;
  logic [SIZE-1:0] rd_b_q, rd_b_d;
  logic [SIZE-2:0] tw_q, tw_d;
  logic [SIZE-1:0] stage_o_q, stage_o_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  wb_t             wb_q [BF_LAT];
  wb_t             wb_d [BF_LAT];

  logic [SIZE-1:0] kx, half, pos, a_nx;

  // State register: FSM, counters, registered outputs and write-back delay line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      stage_q   <= '0;
      cnt_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_a_q    <= '0;
      rd_b_q    <= '0;
      tw_q      <= '0;
      stage_o_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int unsigned i = 0; i < BF_LAT; i++) wb_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      stage_q   <= stage_d;
      cnt_q     <= cnt_d;
      rd_en_q   <= rd_en_d;
      rd_a_q    <= rd_a_d;
      rd_b_q    <= rd_b_d;
      tw_q      <= tw_d;
      stage_o_q <= stage_o_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      for (int unsigned i = 0; i < BF_LAT; i++) wb_q[i] <= wb_d[i];
    end
  end

  // Next-state logic; k_q is the butterfly index being issued while in RUN.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          k_d     = '0;
          stage_d = '0;
        end
      end
      RUN: begin
        if (k_q == K_LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_LAST) begin
          if (stage_q == STAGE_LAST) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            stage_d = stage_q + 1'b1;
            k_d     = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so rd_en_o rises the cycle after start_i.
  // addr_a = grp*2*half + pos is computed as k + (k with the pos bits cleared).
  always_comb begin
    kx   = SIZE'(k_d);
    half = SIZE'(1) << stage_d;
    pos  = kx & (half - SIZE'(1));
    a_nx = kx + (kx & ~(half - SIZE'(1)));

    rd_en_d   = (state_d == RUN);
    rd_a_d    = rd_a_q;
    rd_b_d    = rd_b_q;
    tw_d      = tw_q;
    stage_o_d = stage_d;
    busy_d    = (state_d == RUN) || (state_d == DRAIN);
    done_d    = (state_d == DONE);
    if (state_d == RUN) begin
      rd_a_d = a_nx;
      rd_b_d = a_nx + half;
      tw_d   = (SIZE-1)'(pos) << (STAGE_LAST - stage_d);
    end

    wb_d[0] = '{v: rd_en_q, a: rd_a_q, b: rd_b_q};
    for (int unsigned i = 1; i < BF_LAT; i++) wb_d[i] = wb_q[i-1];
  end

  assign rd_en_o     = rd_en_q;
  assign rd_addr_a_o = rd_a_q;
  assign rd_addr_b_o = rd_b_q;
  assign tw_addr_o   = tw_q;
  assign stage_o     = stage_o_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign wr_en_o     = wb_q[BF_LAT-1].v;
  assign wr_addr_a_o = wb_q[BF_LAT-1].a;
  assign wr_addr_b_o = wb_q[BF_LAT-1].b;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: N=16/BF_LAT=3 instance plus an N=8/BF_LAT=1 instance.
module tb_fft_stage_sequencer;

  localparam int N      = 16;
  localparam int SIZE   = 4;
  localparam int BF_LAT = 3;
  localparam int STRIDE = N/2 + BF_LAT;
  localparam int LAST_C = SIZE * STRIDE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1, start_i = 1'b0;
  logic            rd_en_o, wr_en_o, busy_o, done_o;
  logic [SIZE-1:0] rd_addr_a_o, rd_addr_b_o, wr_addr_a_o, wr_addr_b_o, stage_o;
  logic [SIZE-2:0] tw_addr_o;

  fft_stage_sequencer #(.N(N), .SIZE(SIZE), .BF_LAT(BF_LAT)) u_dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .rd_en_o(rd_en_o), .rd_addr_a_o(rd_addr_a_o), .rd_addr_b_o(rd_addr_b_o),
    .tw_addr_o(tw_addr_o), .wr_en_o(wr_en_o), .wr_addr_a_o(wr_addr_a_o),
    .wr_addr_b_o(wr_addr_b_o), .stage_o(stage_o), .busy_o(busy_o), .done_o(done_o)
  );

  logic       rst_8 = 1'b1, start_8 = 1'b0;
  logic       rd_8, wr_8, busy_8, done_8;
  logic [2:0] ra_8, rb_8, wa_8, wb_8, stage_8;
  logic [1:0] tw_8;

  fft_stage_sequencer #(.N(8), .SIZE(3), .BF_LAT(1)) u_dut8 (
    .clk(clk), .rst(rst_8), .start_i(start_8),
    .rd_en_o(rd_8), .rd_addr_a_o(ra_8), .rd_addr_b_o(rb_8),
    .tw_addr_o(tw_8), .wr_en_o(wr_8), .wr_addr_a_o(wa_8),
    .wr_addr_b_o(wb_8), .stage_o(stage_8), .busy_o(busy_8), .done_o(done_8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int lg_rd [64], lg_wr [64], lg_busy [64], lg_done [64], lg_stage [64];
  int lg_a [64], lg_b [64], lg_tw [64], lg_wa [64], lg_wb [64], lg_all [64];

  typedef struct {
    int cyc;
    int rd, wr, busy, done, stage;
    int a, b, tw, wa, wb;
  } vec_t;
  vec_t vt [10];

  task automatic chk(input string name, input int c, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, c, act, exp);
    end
  endtask

  function automatic void model_addr(input int s, input int k, output int a, output int b,
                                     output int tw);
    int half;
    half = 1 << s;
    a    = (k / half) * 2 * half + (k % half);
    b    = a + half;
    tw   = (k % half) << (SIZE - 1 - s);
  endfunction

  // Expected issue timeline for a run started at cycle 0.
  function automatic bit rd_at(input int c, output int s, output int k);
    s = 0;
    k = 0;
    if (c < 1 || c > LAST_C) return 1'b0;
    s = (c - 1) / STRIDE;
    k = (c - 1) % STRIDE;
    return (k < N/2);
  endfunction

  // Reset, then run ncyc cycles; cycle c is sampled 1 time unit after its clock edge.
  task automatic capture(input int ncyc, input logic [63:0] start_mask, input int rst_at);
    rst = 1'b1;
    start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 0; c < ncyc; c++) begin
      lg_rd[c]    = int'(rd_en_o);
      lg_wr[c]    = int'(wr_en_o);
      lg_busy[c]  = int'(busy_o);
      lg_done[c]  = int'(done_o);
      lg_stage[c] = int'(stage_o);
      lg_a[c]     = int'(rd_addr_a_o);
      lg_b[c]     = int'(rd_addr_b_o);
      lg_tw[c]    = int'(tw_addr_o);
      lg_wa[c]    = int'(wr_addr_a_o);
      lg_wb[c]    = int'(wr_addr_b_o);
      lg_all[c]   = int'({rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o, wr_en_o,
                          wr_addr_a_o, wr_addr_b_o, stage_o, busy_o, done_o});
      start_i = start_mask[c];
      rst     = (c == rst_at);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic check_run(input string tag, input int ncyc);
    int s, k, s2, k2, a, b, tw;
    bit rd_e, wr_e;
    for (int c = 0; c < ncyc; c++) begin
      rd_e = rd_at(c, s, k);
      wr_e = (c >= BF_LAT) ? rd_at(c - BF_LAT, s2, k2) : 1'b0;
      chk({tag, "_rd_en"}, c, lg_rd[c], int'(rd_e));
      chk({tag, "_wr_en"}, c, lg_wr[c], int'(wr_e));
      chk({tag, "_busy"}, c, lg_busy[c], int'(c >= 1 && c <= LAST_C));
      chk({tag, "_done"}, c, lg_done[c], int'(c == LAST_C + 1));
      if (rd_e) begin
        model_addr(s, k, a, b, tw);
        chk({tag, "_stage"}, c, lg_stage[c], s);
        chk({tag, "_rd_a"}, c, lg_a[c], a);
        chk({tag, "_rd_b"}, c, lg_b[c], b);
        chk({tag, "_tw"}, c, lg_tw[c], tw);
      end
      if (wr_e) begin
        model_addr(s2, k2, a, b, tw);
        chk({tag, "_wr_a"}, c, lg_wa[c], a);
        chk({tag, "_wr_b"}, c, lg_wb[c], b);
      end
    end
  endtask

  initial begin
    int s;
    int dups;
    int rd_count;
    logic [7:0] cov8 [3];

    //            cyc rd wr bsy dn stg  a   b  tw  wa  wb
    vt[0] = '{  0, 0, 0, 0, 0,  0,  0,  0, 0,  0,  0};
    vt[1] = '{  1, 1, 0, 1, 0,  0,  0,  1, 0,  0,  0};
    vt[2] = '{  9, 0, 1, 1, 0,  0, 14, 15, 0, 10, 11};
    vt[3] = '{ 12, 1, 0, 1, 0,  1,  0,  2, 0, 14, 15};
    vt[4] = '{ 13, 1, 0, 1, 0,  1,  1,  3, 4, 14, 15};
    vt[5] = '{ 26, 1, 1, 1, 0,  2,  3,  7, 6,  0,  4};
    vt[6] = '{ 39, 1, 1, 1, 0,  3,  5, 13, 5,  2, 10};
    vt[7] = '{ 44, 0, 1, 1, 0,  3,  7, 15, 7,  7, 15};
    vt[8] = '{ 45, 0, 0, 0, 1, -1,  7, 15, 7,  7, 15};
    vt[9] = '{ 46, 0, 0, 0, 0, -1,  7, 15, 7,  7, 15};

    // Reset then idle: every output stays 0.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      chk("idle_outputs", c, int'({rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o, wr_en_o,
                                   wr_addr_a_o, wr_addr_b_o, stage_o, busy_o, done_o}), 0);
    end

    // Full run: table of spot checks including hold behaviour, then full timeline.
    capture(50, 64'h1, -1);
    for (int i = 0; i < 10; i++) begin
      chk("vec_rd_en", vt[i].cyc, lg_rd[vt[i].cyc], vt[i].rd);
      chk("vec_wr_en", vt[i].cyc, lg_wr[vt[i].cyc], vt[i].wr);
      chk("vec_busy", vt[i].cyc, lg_busy[vt[i].cyc], vt[i].busy);
      chk("vec_done", vt[i].cyc, lg_done[vt[i].cyc], vt[i].done);
      if (vt[i].stage >= 0) chk("vec_stage", vt[i].cyc, lg_stage[vt[i].cyc], vt[i].stage);
      chk("vec_rd_a", vt[i].cyc, lg_a[vt[i].cyc], vt[i].a);
      chk("vec_rd_b", vt[i].cyc, lg_b[vt[i].cyc], vt[i].b);
      chk("vec_tw", vt[i].cyc, lg_tw[vt[i].cyc], vt[i].tw);
      chk("vec_wr_a", vt[i].cyc, lg_wa[vt[i].cyc], vt[i].wa);
      chk("vec_wr_b", vt[i].cyc, lg_wb[vt[i].cyc], vt[i].wb);
    end
    check_run("run", 50);

    // Extra start pulses at 10, 30 and 45 (DONE cycle) are ignored.
    capture(60, (64'h1 << 0) | (64'h1 << 10) | (64'h1 << 30) | (64'h1 << 45), -1);
    check_run("ign", 60);

    // Reset mid-run at cycle 20, restart at cycle 25.
    capture(40, (64'h1 << 0) | (64'h1 << 25), 20);
    for (int c = 21; c <= 25; c++) chk("rst_all_zero", c, lg_all[c], 0);
    for (int c = 21; c <= 28; c++) chk("rst_no_wr", c, lg_wr[c], 0);
    chk("rst_restart_rd_en", 26, lg_rd[26], 1);
    chk("rst_restart_stage", 26, lg_stage[26], 0);
    chk("rst_restart_a", 26, lg_a[26], 0);
    chk("rst_restart_b", 26, lg_b[26], 1);
    chk("rst_restart_tw", 26, lg_tw[26], 0);
    chk("rst_restart_busy", 26, lg_busy[26], 1);
    chk("rst_restart_wr_en", 29, lg_wr[29], 1);
    chk("rst_restart_wr_a", 29, lg_wa[29], 0);
    chk("rst_restart_wr_b", 29, lg_wb[29], 1);

    // N=8, BF_LAT=1: done at cycle 16 and full per-stage address coverage.
    rst_8 = 1'b1;
    start_8 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_8 = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cov8[i] = '0;
    dups = 0;
    rd_count = 0;
    for (int c = 0; c < 26; c++) begin
      chk("n8_done", c, int'(done_8), int'(c == 16));
      chk("n8_busy", c, int'(busy_8), int'(c >= 1 && c <= 15));
      if (rd_8) begin
        rd_count++;
        s = (c - 1) / 5;
        if (s < 3) begin
          chk("n8_stage", c, int'(stage_8), s);
          if (cov8[s][ra_8]) dups++;
          cov8[s][ra_8] = 1'b1;
          if (cov8[s][rb_8]) dups++;
          cov8[s][rb_8] = 1'b1;
        end
      end
      start_8 = (c == 0);
      @(posedge clk);
      #1;
    end
    start_8 = 1'b0;
    for (int i = 0; i < 3; i++) chk("n8_coverage", i, int'(cov8[i]), 255);
    chk("n8_duplicates", 0, dups, 0);
    chk("n8_read_count", 0, rd_count, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
